mem_arbiter: RTL and testbench

Two-port write arbiter that shares the single `mem_ctrl` write port between the `core` and a second bus master (debug loader / DMA). Each port has a small posted-write FIFO. A round-robin scheduler drains one write per cycle into registered `mem_addr`/`mem_data`/`mem_we` outputs. The block sits between the requesters and `mem_ctrl` inside `cpu_top`.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port posted-write arbiter onto the single mem_ctrl write port
//
// Purpose: each requester (port 0 = core, port 1 = aux master) has a DEPTH-entry
// posted-write FIFO. A round-robin scheduler drains at most one write per cycle
// into registered mem_addr/mem_data/mem_we outputs.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   p0_valid/ready/addr/data  port 0 write request handshake and payload
//   p1_valid/ready/addr/data  port 1 write request handshake and payload
//   mem_addr, mem_data    registered write address/data to mem_ctrl
//   mem_we                registered write strobe, one cycle per write
//   busy                  any FIFO non-empty or a write strobe in flight
module mem_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q  [2][DEPTH];
    logic [DATA_W-1:0] data_q  [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr  [2];
    logic [PTR_W-1:0]  rd_ptr  [2];
    logic [CNT_W-1:0]  count   [2];
    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        in_valid;
    logic [1:0]        ready;
    logic [1:0]        nonempty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              prio;

    assign in_addr[0] = p0_addr;
    assign in_addr[1] = p1_addr;
    assign in_data[0] = p0_data;
    assign in_data[1] = p1_data;
    assign in_valid   = {p1_valid, p0_valid};

    // Ready depends on the count alone; a same-cycle pop does not free a slot early.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i]    = (count[i] != FULL_CNT);
            nonempty[i] = (count[i] != '0);
        end
    end

    assign push     = in_valid & ready;
    assign p0_ready = ready[0];
    assign p1_ready = ready[1];

    // A lone non-empty FIFO is always served; on a tie prio picks the winner.
    always_comb begin
        pop = nonempty;
        if (&nonempty) begin
            pop = prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                addr_q[i][wr_ptr[i]] <= in_addr[i];
                data_q[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    // The port just served loses the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            prio     <= 1'b0;
        end else begin
            mem_we <= |pop;
            if (pop[0]) begin
                mem_addr <= addr_q[0][rd_ptr[0]];
                mem_data <= data_q[0][rd_ptr[0]];
                prio     <= 1'b1;
            end else if (pop[1]) begin
                mem_addr <= addr_q[1][rd_ptr[1]];
                mem_data <= data_q[1][rd_ptr[1]];
                prio     <= 1'b0;
            end
        end
    end

    assign busy = nonempty[0] | nonempty[1] | mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a queue-based reference model
module tb_mem_arbiter;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        p0_valid, p1_valid;
    logic        p0_ready, p1_ready;
    logic [31:0] p0_addr, p0_data, p1_addr, p1_data;
    logic [31:0] mem_addr, mem_data;
    logic        mem_we, busy;

    mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [31:0] seen[$];
    logic        m_prio, m_we;
    logic [31:0] m_addr, m_data;
    logic        acc0, acc1;
    int          checks = 0;
    int          failures = 0;
    int          accepts = 0;
    int          strobes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs against the model, take the edge, advance the model.
    task automatic cycle();
        ent_t e;
        logic a0, a1;
        chk("p0_ready", p0_ready, q0.size() != DEPTH);
        chk("p1_ready", p1_ready, q1.size() != DEPTH);
        chk("busy", busy, (q0.size() != 0) || (q1.size() != 0) || m_we);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_data);
        a0 = p0_valid && (q0.size() != DEPTH);
        a1 = p1_valid && (q1.size() != DEPTH);
        @(posedge clk);
        if (q0.size() != 0 && (q1.size() == 0 || m_prio == 1'b0)) begin
            e = q0.pop_front();
            m_we = 1'b1; m_addr = e.a; m_data = e.d; m_prio = 1'b1;
        end else if (q1.size() != 0) begin
            e = q1.pop_front();
            m_we = 1'b1; m_addr = e.a; m_data = e.d; m_prio = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (a0) begin q0.push_back({p0_addr, p0_data}); accepts++; end
        if (a1) begin q1.push_back({p1_addr, p1_data}); accepts++; end
        acc0 = a0;
        acc1 = a1;
        #1;
        if (mem_we === 1'b1) begin
            seen.push_back(mem_addr);
            strobes++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_data"}, mem_data, 32'h0);
        chk({tag, "_rdy0"}, p0_ready, 1'b1);
        chk({tag, "_rdy1"}, p1_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic reset_assert(input string tag);
        rst_n = 1'b0;
        #1;
        q0.delete(); q1.delete(); seen.delete();
        m_prio = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
        acc0 = 1'b0; acc1 = 1'b0; accepts = 0; strobes = 0;
        chk_reset_outputs({tag, "_assert"});
    endtask

    task automatic reset_release(input string tag);
        @(posedge clk); #1;
        chk_reset_outputs({tag, "_hold"});
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while ((p0_valid || p1_valid || q0.size() != 0 || q1.size() != 0 || m_we) && c < 60) begin
            cycle();
            if (acc0) p0_valid = 1'b0;
            if (acc1) p1_valid = 1'b0;
            c++;
        end
        chk({tag, "_drain_timeout"}, c < 60, 1'b1);
    endtask

    initial begin
        int n;
        logic low_seen, recovered;
        rst_n = 1'b0;
        p0_valid = 1'b0; p1_valid = 1'b0;
        p0_addr = '0; p0_data = '0; p1_addr = '0; p1_data = '0;
        #2;

        // Reset with both ports requesting, then first-accept latency.
        p0_valid = 1'b1; p0_addr = 32'hAA0; p0_data = 32'h1111;
        p1_valid = 1'b1; p1_addr = 32'hBB0; p1_data = 32'h2222;
        reset_assert("rst");
        reset_release("rst");
        cycle();
        chk("lat_acc", acc0, 1'b1);
        p0_valid = 1'b0; p1_valid = 1'b0;
        chk("lat_we_early", mem_we, 1'b0);
        cycle();
        chk("lat_we", mem_we, 1'b1);
        chk("lat_addr", mem_addr, 32'hAA0);
        drain("lat");

        // Single port stream of three writes.
        seen.delete();
        for (int k = 0; k < 3; k++) begin
            p0_valid = 1'b1; p0_addr = 32'h10 + 32'(4 * k); p0_data = 32'hA + 32'(k);
            cycle();
            chk("sp_acc", acc0, 1'b1);
        end
        p0_valid = 1'b0;
        chk("sp_we_run", mem_we, 1'b1);
        drain("sp");
        chk("sp_count", seen.size(), 3);
        chk("sp_0", seen[0], 32'h10);
        chk("sp_1", seen[1], 32'h14);
        chk("sp_2", seen[2], 32'h18);

        // Contention from a clean reset: strict alternation starting with port 0.
        reset_assert("ct");
        reset_release("ct");
        p0_valid = 1'b1; p0_addr = 32'h100; p0_data = 32'hC0;
        p1_valid = 1'b1; p1_addr = 32'h200; p1_data = 32'hD0;
        cycle();
        p0_addr = 32'h104; p0_data = 32'hC1;
        p1_addr = 32'h204; p1_data = 32'hD1;
        cycle();
        chk("ct_acc", {acc0, acc1}, 2'b11);
        p0_valid = 1'b0; p1_valid = 1'b0;
        drain("ct");
        chk("ct_count", seen.size(), 4);
        chk("ct_0", seen[0], 32'h100);
        chk("ct_1", seen[1], 32'h200);
        chk("ct_2", seen[2], 32'h104);
        chk("ct_3", seen[3], 32'h204);
        // prio back at 0: a fresh simultaneous pair serves port 0 first.
        p0_valid = 1'b1; p0_addr = 32'h108; p0_data = 32'hC2;
        p1_valid = 1'b1; p1_addr = 32'h208; p1_data = 32'hD2;
        cycle();
        p0_valid = 1'b0; p1_valid = 1'b0;
        drain("ct2");
        chk("ct_prio0", seen[4], 32'h108);
        chk("ct_prio1", seen[5], 32'h208);

        // Back-pressure: port 1 always requesting while port 0 streams.
        reset_assert("bp");
        reset_release("bp");
        low_seen = 1'b0; recovered = 1'b0;
        p0_valid = 1'b1; p0_addr = 32'h400; p0_data = $urandom;
        p1_valid = 1'b1; p1_addr = 32'h500; p1_data = $urandom;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (p0_ready === 1'b0) low_seen = 1'b1;
            else if (low_seen) recovered = 1'b1;
            if (acc0) begin p0_addr = p0_addr + 4; p0_data = $urandom; end
            if (acc1) begin p1_addr = p1_addr + 4; p1_data = $urandom; end
        end
        chk("bp_full", low_seen, 1'b1);
        chk("bp_recover", recovered, 1'b1);
        drain("bp");
        chk("bp_total", strobes, accepts);

        // Wrap-around: 2*DEPTH+1 writes on port 0 with random gaps.
        seen.delete();
        n = 0;
        p0_valid = 1'b0;
        for (int c = 0; c < 200 && n < 2 * DEPTH + 1; c++) begin
            if (!p0_valid && $urandom_range(0, 2) != 0) begin
                p0_valid = 1'b1; p0_addr = 32'h300 + 32'(4 * n); p0_data = $urandom;
            end
            cycle();
            if (acc0) begin n++; p0_valid = 1'b0; end
        end
        chk("wr_accepts", n, 2 * DEPTH + 1);
        drain("wr");
        chk("wr_count", seen.size(), 2 * DEPTH + 1);
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            chk("wr_order", seen[k], 32'h300 + 32'(4 * k));
        end

        // Reset mid-flight discards queued writes and drops the strobe at once.
        p0_valid = 1'b1; p0_addr = 32'h600; p0_data = $urandom;
        p1_valid = 1'b1; p1_addr = 32'h700; p1_data = $urandom;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (acc0) begin p0_addr = p0_addr + 4; p0_data = $urandom; end
            if (acc1) begin p1_addr = p1_addr + 4; p1_data = $urandom; end
        end
        chk("mf_we_before", mem_we, 1'b1);
        chk("mf_busy_before", busy, 1'b1);
        p0_valid = 1'b0; p1_valid = 1'b0;
        reset_assert("mf");
        reset_release("mf");
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("mf_idle_busy", busy, 1'b0);
        end
        chk("mf_no_stale", strobes, 0);
        p0_valid = 1'b1; p0_addr = 32'h800; p0_data = 32'h55;
        cycle();
        p0_valid = 1'b0;
        chk("mf_busy_new", busy, 1'b1);
        drain("mf");

        // Randomized traffic on both ports against the model.
        reset_assert("rnd");
        reset_release("rnd");
        for (int k = 0; k < 400; k++) begin
            if (!p0_valid || acc0) begin
                p0_valid = 1'($urandom_range(0, 1)); p0_addr = $urandom; p0_data = $urandom;
            end
            if (!p1_valid || acc1) begin
                p1_valid = 1'($urandom_range(0, 1)); p1_addr = $urandom; p1_data = $urandom;
            end
            cycle();
        end
        drain("rnd");
        chk("rnd_total", strobes, accepts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
